// File: rtl/conv_mac4.sv
// Four-lane signed multiply-accumulate: TAPS beats per result, then an arithmetic
// shift and saturation to OUT_W bits, presented with a one-cycle out_ready pulse.
module conv_mac4 #(
    parameter int DATA_W = 5,
    parameter int OUT_W  = 5,
    parameter int ACC_W  = 16,
    parameter int TAPS   = 9,
    parameter int SHIFT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a0,
    input  logic signed [DATA_W-1:0] a1,
    input  logic signed [DATA_W-1:0] a2,
    input  logic signed [DATA_W-1:0] a3,
    input  logic signed [DATA_W-1:0] w0,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] w2,
    input  logic signed [DATA_W-1:0] w3,
    output logic                     busy,
    output logic                     out_ready,
    output logic signed [OUT_W-1:0]  out0,
    output logic signed [OUT_W-1:0]  out1,
    output logic signed [OUT_W-1:0]  out2,
    output logic signed [OUT_W-1:0]  out3
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_ready_q, out_ready_d;
    logic             clear_acc;
    logic             accept_beat;
    logic             load_out;

    logic signed [DATA_W-1:0] a_vec [4];
    logic signed [DATA_W-1:0] w_vec [4];
    logic signed [OUT_W-1:0]  out_vec [4];

    assign a_vec[0] = a0;
    assign a_vec[1] = a1;
    assign a_vec[2] = a2;
    assign a_vec[3] = a3;
    assign w_vec[0] = w0;
    assign w_vec[1] = w1;
    assign w_vec[2] = w2;
    assign w_vec[3] = w3;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        clear_acc   = 1'b0;
        accept_beat = 1'b0;
        load_out    = 1'b0;
        out_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A beat presented together with start is deliberately dropped.
                if (start) begin
                    clear_acc = 1'b1;
                    count_d   = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    accept_beat = 1'b1;
                    count_d     = count_q + 1'b1;
                    if (count_q == CNT_W'(TAPS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                load_out    = 1'b1;
                out_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_ready_q <= out_ready_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]    acc_q, acc_d;
            logic signed [ACC_W-1:0]    shifted;
            logic signed [OUT_W-1:0]    out_q, out_d;

            assign prod    = a_vec[gi] * w_vec[gi];
            assign shifted = acc_q >>> SHIFT;

            always_comb begin
                acc_d = acc_q;
                if (clear_acc) begin
                    acc_d = '0;
                end else if (accept_beat) begin
                    acc_d = acc_q + ACC_W'(prod);
                end
            end

            always_comb begin
                out_d = out_q;
                if (load_out) begin
                    if (shifted > SAT_MAX) begin
                        out_d = SAT_MAX[OUT_W-1:0];
                    end else if (shifted < SAT_MIN) begin
                        out_d = SAT_MIN[OUT_W-1:0];
                    end else begin
                        out_d = shifted[OUT_W-1:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                    out_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    out_q <= out_d;
                end
            end

            assign out_vec[gi] = out_q;
        end
    endgenerate

    assign busy      = (state_q != IDLE);
    assign out_ready = out_ready_q;
    assign out0      = out_vec[0];
    assign out1      = out_vec[1];
    assign out2      = out_vec[2];
    assign out3      = out_vec[3];

endmodule
